// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding, FIFO entry
// layout and baud-divider helpers used by the RX path (and later the TX path).
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } rx_state_e;

  // Data is sized for the widest legal frame; narrower frames are zero-extended.
  typedef struct packed {
    logic                     parity_err;
    logic                     frame_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  // Clock cycles per serial bit.
  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    return (clk_fre * 1000000) / baud_rate;
  endfunction

  // Assemble one FIFO entry.
  function automatic rx_entry_t make_entry(input logic                     parity_err,
                                           input logic                     frame_err,
                                           input logic [MAX_DATA_BITS-1:0] data);
    rx_entry_t e;
    e.parity_err = parity_err;
    e.frame_err  = frame_err;
    e.data       = data;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl_if.sv
// Consumer-side handshake of the UART receiver: head-of-FIFO data with its
// error flags, qualified by valid and accepted by ready.
interface uart_rx_fifo_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_data_valid;
  logic                 rx_data_ready;

  modport master (
    output rx_data,
    output rx_frame_err,
    output rx_parity_err,
    output rx_data_valid,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_frame_err,
    input  rx_parity_err,
    input  rx_data_valid,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always visible on
// o_pop_data; a push is visible the cycle after it is written. Pointers carry
// one extra wrap bit so full and empty can be told apart.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
    $error("uart_sync_fifo: DEPTH must be a power of two and >= 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop & ~o_empty;
  // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_count    = r_wr_ptr - r_rd_ptr;

  // Advance write/read pointers on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; cleared on reset so the head reads 0 before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receiver: synchronised input, start validation, 3-sample majority vote
// at mid-bit, optional parity and 1/2 stop bits. Completed frames (with their
// error flags) are queued in a FIFO drained by a valid/ready consumer.
module uart_rx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 1500000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_pin,
  uart_rx_fifo_ctrl_if.master rx_if,
  output logic                rx_overrun,
  output logic                rx_busy
);
  localparam int          CYCLE      = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] HALF_CNT   = 16'(CYCLE / 2);
  localparam logic [15:0] LAST_CNT   = 16'(CYCLE - 1);
  localparam int          BW         = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic        HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic        PAR_IS_ODD = (PARITY == PAR_ODD);

  if (CYCLE < 8) begin : g_chk_cycle
    $error("uart_rx_fifo_ctrl: CLK_FRE*1e6/BAUD_RATE must be >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > MAX_DATA_BITS)) begin : g_chk_data
    $error("uart_rx_fifo_ctrl: DATA_BITS must be 5..9");
  end
  if ((PARITY < PAR_NONE) || (PARITY > PAR_EVEN)) begin : g_chk_par
    $error("uart_rx_fifo_ctrl: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
    $error("uart_rx_fifo_ctrl: STOP_BITS must be 1 or 2");
  end

  // Input path
  logic       r_sync0;
  logic       r_sync1;
  logic [1:0] r_hist;
  logic       w_fall;
  logic       w_vote;

  // Bit engine
  rx_state_e            r_state;
  logic [15:0]          r_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic [DATA_BITS-1:0] r_bits;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_busy;
  logic                 r_push;
  rx_entry_t            r_push_entry;
  logic                 w_mid;
  logic                 w_end;

  // FIFO side
  rx_entry_t                    w_head;
  logic                         w_fifo_full;
  logic                         w_fifo_empty;
  logic                         w_pop;
  logic [$clog2(FIFO_DEPTH):0]  w_fifo_count;
  logic                         r_overrun;
  logic                         w_unused_fifo;

  // Two-flop synchroniser plus two older samples; both flops idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync0 <= 1'b1;
      r_sync1 <= 1'b1;
      r_hist  <= 2'b11;
    end else begin
      r_sync0 <= rx_pin;
      r_sync1 <= r_sync0;
      r_hist  <= {r_hist[0], r_sync1};
    end
  end

  // Sample window {r_hist[1], r_hist[0], r_sync1} = counts CYCLE/2-2 .. CYCLE/2.
  assign w_fall = r_hist[0] & ~r_sync1;
  assign w_vote = (r_sync1 & r_hist[0]) | (r_sync1 & r_hist[1]) | (r_hist[0] & r_hist[1]);
  assign w_mid  = (r_cnt == HALF_CNT);
  assign w_end  = (r_cnt == LAST_CNT);

  // Receive state machine with registered busy and push outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 16'd0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_bits       <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_busy       <= 1'b0;
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 16'd0;
          if (w_fall) begin
            r_state      <= S_START;
            r_busy       <= 1'b1;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (w_mid && w_vote) begin
            // Line back high at mid-bit: glitch, not a start bit.
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end else if (w_end) begin
            r_state <= S_DATA;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shift in from the top.
          if (w_mid) r_bits <= {w_vote, r_bits[DATA_BITS-1:1]};
          if (w_end) begin
            r_cnt <= 16'd0;
            if (r_bit_cnt == BIT_LAST) begin
              r_state <= HAS_PARITY ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_mid) r_parity_err <= (^r_bits) ^ w_vote ^ PAR_IS_ODD;
          if (w_end) begin
            r_state <= S_STOP;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_mid && (r_stop_cnt == STOP_LAST)) begin
            // Leave at mid-bit so a back-to-back start edge is not missed.
            r_push       <= 1'b1;
            r_push_entry <= make_entry(r_parity_err, r_frame_err | ~w_vote,
                                       MAX_DATA_BITS'(r_bits));
            r_state      <= S_IDLE;
            r_cnt        <= 16'd0;
            r_busy       <= 1'b0;
          end else begin
            if (w_mid && !w_vote) r_frame_err <= 1'b1;
            if (w_end) begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
              r_cnt      <= 16'd0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 16'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_pop = ~w_fifo_empty & rx_if.rx_data_ready;

  uart_sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_push),
    .i_push_data (r_push_entry),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Flag a completed frame that found the FIFO full with nothing leaving.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_push & w_fifo_full & ~w_pop;
    end
  end

  assign rx_if.rx_data       = w_head.data[DATA_BITS-1:0];
  assign rx_if.rx_frame_err  = w_head.frame_err;
  assign rx_if.rx_parity_err = w_head.parity_err;
  assign rx_if.rx_data_valid = ~w_fifo_empty;
  assign rx_overrun          = r_overrun;
  assign rx_busy             = r_busy;

  // Upper data bits and occupancy are not needed by this consumer port.
  assign w_unused_fifo = ^{w_head.data, w_fifo_count};

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl. DUT A: 8N1, DUT B: 8E2; both at
// CYCLE = 50. Frames are driven on the pins; the expected entry
// {parity_err, frame_err, data} is queued at send time and a monitor pops and
// compares whenever a DUT hands over an entry.
module tb_uart_rx_fifo_ctrl;
  localparam int CYC = 50;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic ovr_a, busy_a, ovr_b, busy_b;

  int n_checks = 0;
  int n_errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];

  uart_rx_fifo_ctrl_if #(.DATA_BITS(8)) if_a ();
  uart_rx_fifo_ctrl_if #(.DATA_BITS(8)) if_b ();

  always #10 clk = ~clk;

  uart_rx_fifo_ctrl #(
    .CLK_FRE(50), .BAUD_RATE(1000000), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(rst), .rx_pin(rx_a), .rx_if(if_a),
    .rx_overrun(ovr_a), .rx_busy(busy_a)
  );

  uart_rx_fifo_ctrl #(
    .CLK_FRE(50), .BAUD_RATE(1000000), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(rst), .rx_pin(rx_b), .rx_if(if_b),
    .rx_overrun(ovr_b), .rx_busy(busy_b)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
    end
  endtask

  // Hold one pin level for n clocks; returns at posedge+1.
  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx_a = v;
    else            rx_b = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send nb bits, bit 0 first, each one bit time long.
  task automatic send(input int which, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) drive(which, bits[i], CYC);
  endtask

  task automatic wait_drain(input int which, input string nm);
    int left;
    for (int i = 0; i < 8 * CYC; i++) begin
      left = (which == 0) ? exp_a.size() : exp_b.size();
      if (left == 0) break;
      @(posedge clk);
      #1;
    end
    left = (which == 0) ? exp_a.size() : exp_b.size();
    check(nm, left, 0);
  endtask

  // Monitor: compare every accepted head entry against the scoreboard.
  initial begin
    logic [9:0] got;
    logic [9:0] want;
    forever begin
      @(negedge clk);
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (!rst && if_a.rx_data_valid && if_a.rx_data_ready) begin
        got = {if_a.rx_parity_err, if_a.rx_frame_err, if_a.rx_data};
        n_checks++;
        if (exp_a.size() == 0) begin
          n_errors++;
          $display("FAIL sb_a_unexpected: got entry 0x%03h, expected none", got);
        end else begin
          want = exp_a.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL sb_a: got par=%0b frm=%0b data=0x%02h, expected par=%0b frm=%0b data=0x%02h",
                     got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
          end
        end
      end
      if (!rst && if_b.rx_data_valid && if_b.rx_data_ready) begin
        got = {if_b.rx_parity_err, if_b.rx_frame_err, if_b.rx_data};
        n_checks++;
        if (exp_b.size() == 0) begin
          n_errors++;
          $display("FAIL sb_b_unexpected: got entry 0x%03h, expected none", got);
        end else begin
          want = exp_b.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL sb_b: got par=%0b frm=%0b data=0x%02h, expected par=%0b frm=%0b data=0x%02h",
                     got[9], got[8], got[7:0], want[9], want[8], want[7:0]);
          end
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected bench completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int waited;
    if_a.rx_data_ready = 1'b1;
    if_b.rx_data_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid_a", if_a.rx_data_valid, 0);
    check("rst_data_a",  if_a.rx_data, 0);
    check("rst_frm_a",   if_a.rx_frame_err, 0);
    check("rst_par_b",   if_b.rx_parity_err, 0);
    check("rst_busy_a",  busy_a, 0);
    check("rst_ovr_a",   ovr_a, 0);
    rst = 1'b0;
    drive(0, 1'b1, 20);
    check("idle_busy_a", busy_a, 0);

    // 0xA5, 8N1; valid expected ~CYCLE/2+6 clocks after the stop bit starts
    exp_a.push_back({2'b00, 8'hA5});
    send(0, {8'hA5, 1'b0}, 9);
    rx_a = 1'b1;
    lat  = -1;
    for (int i = 1; i <= CYC; i++) begin
      @(negedge clk);
      if (lat < 0 && if_a.rx_data_valid) lat = i;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (lat < CYC / 2 + 1 || lat > CYC / 2 + 8) begin
      n_errors++;
      $display("FAIL lat_a5: got %0d clocks, expected %0d..%0d", lat, CYC / 2 + 1, CYC / 2 + 8);
    end
    drive(0, 1'b1, 20);
    wait_drain(0, "drain_a5");

    // 0x00 with a one-clock high glitch landing on the mid-bit sample of bit 3
    exp_a.push_back({2'b00, 8'h00});
    send(0, 16'h0000, 4);
    drive(0, 1'b0, 26);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 23);
    send(0, 16'h0010, 5);
    drive(0, 1'b1, 20);
    wait_drain(0, "drain_glitch");

    // False start: 10 clocks low, then idle
    drive(0, 1'b0, 10);
    check("false_busy_hi", busy_a, 1);
    rx_a   = 1'b1;
    waited = 0;
    while (busy_a && waited < CYC) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("false_busy_lo", busy_a, 0);
    drive(0, 1'b1, 2 * CYC);
    check("false_no_push", if_a.rx_data_valid, 0);

    // Stop bit 0 on 0x5A
    exp_a.push_back({2'b01, 8'h5A});
    send(0, {1'b0, 8'h5A, 1'b0}, 10);
    drive(0, 1'b1, 20);
    wait_drain(0, "drain_5a");

    // Break: line low for 15 bit times -> exactly one frame_err entry of 0
    exp_a.push_back({2'b01, 8'h00});
    drive(0, 1'b0, 15 * CYC);
    check("break_busy", busy_a, 0);
    drive(0, 1'b1, 2 * CYC);
    wait_drain(0, "drain_break");

    // Overrun: consumer stalled, five frames back-to-back into a depth-4 FIFO
    if_a.rx_data_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_a.push_back({2'b00, 8'(i)});
    for (int i = 1; i <= 5; i++) send(0, {1'b1, 8'(i), 1'b0}, 10);
    drive(0, 1'b1, 40);
    check("ovr_pulses", ovr_cnt_a, 1);
    check("ovr_head_valid", if_a.rx_data_valid, 1);
    check("ovr_head_data", if_a.rx_data, 8'h01);
    if_a.rx_data_ready = 1'b1;
    wait_drain(0, "drain_ovr");
    drive(0, 1'b1, 2);
    check("ovr_empty", if_a.rx_data_valid, 0);

    // Reset during bit 3 of 0xFF, then a clean 0x3C
    send(0, {3'b111, 1'b0}, 4);
    drive(0, 1'b1, 25);
    rst = 1'b1;
    drive(0, 1'b1, 3);
    check("rst_mid_busy", busy_a, 0);
    check("rst_mid_valid", if_a.rx_data_valid, 0);
    rst = 1'b0;
    drive(0, 1'b1, 20);
    exp_a.push_back({2'b00, 8'h3C});
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    drive(0, 1'b1, 20);
    wait_drain(0, "drain_3c");

    // Even parity, two stop bits. Frame = {stop2, stop1, parity, data, start}
    exp_b.push_back({2'b00, 8'h37});
    send(1, {1'b1, 1'b1, 1'b1, 8'h37, 1'b0}, 12);
    drive(1, 1'b1, 20);
    exp_b.push_back({2'b10, 8'h37});
    send(1, {1'b1, 1'b1, 1'b0, 8'h37, 1'b0}, 12);
    drive(1, 1'b1, 20);
    exp_b.push_back({2'b01, 8'h37});
    send(1, {1'b0, 1'b1, 1'b1, 8'h37, 1'b0}, 12);
    drive(1, 1'b1, 20);
    exp_b.push_back({2'b00, 8'hC3});
    send(1, {1'b1, 1'b1, 1'b0, 8'hC3, 1'b0}, 12);
    drive(1, 1'b1, 20);
    wait_drain(1, "drain_b");
    check("ovr_b_none", ovr_cnt_b, 0);
    check("end_queue_a", exp_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
